// File: rtl/refmap_window_checker_if.sv
// Handshake bundle between a refinement-check wrapper (master) and the
// window checker (slave).
interface refmap_window_checker_if #(
  parameter int NUM_MAPS = 18,
  parameter int CNT_W    = 4,
  parameter int IDX_W    = 5
);
  logic                issue, ila_valid, ila_decode, end_cond;
  logic [NUM_MAPS-1:0] map_ok, map_en;
  logic                start, started, ended, ended2;
  logic [CNT_W-1:0]    cycle_cnt;
  logic                pass, fail, fail_sticky, timeout;
  logic [IDX_W-1:0]    fail_map_idx;
  logic [CNT_W-1:0]    fail_cycle;
  logic [15:0]         instr_count;

  modport master (
    output issue, ila_valid, ila_decode, end_cond, map_ok, map_en,
    input  start, started, ended, ended2, cycle_cnt, pass, fail,
           fail_sticky, timeout, fail_map_idx, fail_cycle, instr_count
  );
  modport slave (
    input  issue, ila_valid, ila_decode, end_cond, map_ok, map_en,
    output start, started, ended, ended2, cycle_cnt, pass, fail,
           fail_sticky, timeout, fail_map_idx, fail_cycle, instr_count
  );
endinterface

// File: rtl/refmap_window_checker.sv
// Sequences one ILA instruction window (issue/start/run/end/end2) and checks
// the per-lane refinement-map results at each end event.
module refmap_window_checker #(
  parameter int NUM_MAPS   = 18,
  parameter int MAX_CYCLES = 6,
  parameter int CNT_W      = 4,
  parameter int END_MIN    = 1,
  parameter int END_MAX    = 1,
  parameter int REPEAT     = 0,
  parameter int IDX_W      = 5
) (
  input logic clk,
  input logic rst,
  refmap_window_checker_if.slave bus
);
  localparam logic [CNT_W-1:0] END_MIN_C = CNT_W'(END_MIN);
  localparam logic [CNT_W-1:0] END_MAX_C = CNT_W'(END_MAX);
  localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_CYCLES);

  typedef enum logic [2:0] {IDLE, START, RUN, POST, DONE} state_t;
  state_t state;

  logic [NUM_MAPS-1:0] mis;
  logic [IDX_W-1:0]    mis_idx;
  logic [CNT_W-1:0]    cnt_nxt;
  logic                in_win, iend, tmo, post_end, chk, bad;

  // Lowest failing enabled lane wins.
  always_comb begin
    mis     = bus.map_en & ~bus.map_ok;
    mis_idx = '0;
    for (int i = NUM_MAPS-1; i >= 0; i--)
      if (mis[i]) mis_idx = IDX_W'(i);
  end

  assign cnt_nxt  = (bus.cycle_cnt < MAX_C) ? bus.cycle_cnt + CNT_W'(1) : bus.cycle_cnt;
  assign in_win   = (bus.cycle_cnt >= END_MIN_C) && (bus.cycle_cnt <= END_MAX_C);
  assign iend     = (state == RUN) && bus.end_cond && in_win;
  // An end event on the last window cycle pre-empts the timeout.
  assign tmo      = (state == RUN) && !iend && (bus.cycle_cnt == END_MAX_C);
  assign post_end = (state == POST) && bus.end_cond;
  assign chk      = iend | tmo | post_end;
  assign bad      = tmo | (|mis);

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      bus.start        <= 1'b0;
      bus.started      <= 1'b0;
      bus.ended        <= 1'b0;
      bus.ended2       <= 1'b0;
      bus.cycle_cnt    <= '0;
      bus.pass         <= 1'b0;
      bus.fail         <= 1'b0;
      bus.fail_sticky  <= 1'b0;
      bus.timeout      <= 1'b0;
      bus.fail_map_idx <= '0;
      bus.fail_cycle   <= '0;
      bus.instr_count  <= '0;
    end else begin
      bus.start <= 1'b0;
      bus.pass  <= 1'b0;
      bus.fail  <= 1'b0;
      if (chk) begin
        bus.pass <= !bad;
        bus.fail <= bad;
        if (bad && !bus.fail_sticky) begin
          bus.fail_sticky  <= 1'b1;
          bus.fail_map_idx <= tmo ? '0 : mis_idx;
          bus.fail_cycle   <= bus.cycle_cnt;
        end
      end
      if (state inside {START, RUN, POST}) bus.cycle_cnt <= cnt_nxt;
      case (state)
        IDLE:
          if (bus.issue && bus.ila_valid && bus.ila_decode) begin
            state     <= START;
            bus.start <= 1'b1;
          end
        START: begin
          state       <= RUN;
          bus.started <= 1'b1;
        end
        RUN:
          if (iend || tmo) begin
            state     <= POST;
            bus.ended <= 1'b1;
            if (tmo) bus.timeout <= 1'b1;
          end
        POST:
          if (bus.end_cond) begin
            bus.ended2 <= 1'b1;
            if (bus.instr_count != 16'hFFFF) bus.instr_count <= bus.instr_count + 16'd1;
            if (REPEAT != 0) begin
              state         <= IDLE;
              bus.started   <= 1'b0;
              bus.ended     <= 1'b0;
              bus.ended2    <= 1'b0;
              bus.cycle_cnt <= '0;
            end else begin
              state <= DONE;
            end
          end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_refmap_window_checker.sv
// Directed bench: three checker instances (defaults, widened end window,
// back-to-back re-issue) driven by one linear stimulus sequence.
module tb_refmap_window_checker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  refmap_window_checker_if #(.NUM_MAPS(18), .CNT_W(4), .IDX_W(5)) b0 ();
  refmap_window_checker_if #(.NUM_MAPS(18), .CNT_W(4), .IDX_W(5)) b1 ();
  refmap_window_checker_if #(.NUM_MAPS(18), .CNT_W(4), .IDX_W(5)) b2 ();

  refmap_window_checker #(.NUM_MAPS(18), .MAX_CYCLES(6), .CNT_W(4), .END_MIN(1),
    .END_MAX(1), .REPEAT(0), .IDX_W(5)) u0 (.clk(clk), .rst(rst), .bus(b0));
  refmap_window_checker #(.NUM_MAPS(18), .MAX_CYCLES(6), .CNT_W(4), .END_MIN(2),
    .END_MAX(4), .REPEAT(0), .IDX_W(5)) u1 (.clk(clk), .rst(rst), .bus(b1));
  refmap_window_checker #(.NUM_MAPS(18), .MAX_CYCLES(6), .CNT_W(4), .END_MIN(1),
    .END_MAX(1), .REPEAT(1), .IDX_W(5)) u2 (.clk(clk), .rst(rst), .bus(b2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    b0.issue = 0; b0.ila_valid = 0; b0.ila_decode = 0; b0.end_cond = 0; b0.map_ok = '1; b0.map_en = '1;
    b1.issue = 0; b1.ila_valid = 0; b1.ila_decode = 0; b1.end_cond = 0; b1.map_ok = '1; b1.map_en = '1;
    b2.issue = 0; b2.ila_valid = 0; b2.ila_decode = 0; b2.end_cond = 0; b2.map_ok = '1; b2.map_en = '1;
    rst = 1;
    tick(); tick();
    chk("rst_start", b0.start, 0);
    chk("rst_started", b0.started, 0);
    chk("rst_cnt", b0.cycle_cnt, 0);
    chk("rst_sticky", b0.fail_sticky, 0);
    chk("rst_icount", b2.instr_count, 0);

    // ---- defaults: passing window ----
    rst = 0;
    b0.issue = 1; b0.ila_valid = 1; b0.ila_decode = 1;
    tick();
    chk("t1_start", b0.start, 1);
    chk("t1_cnt0", b0.cycle_cnt, 0);
    chk("t1_started_lo", b0.started, 0);
    b0.issue = 0;
    tick();
    chk("t1_started", b0.started, 1);
    chk("t1_start_lo", b0.start, 0);
    chk("t1_cnt1", b0.cycle_cnt, 1);
    b0.end_cond = 1;
    tick();
    chk("t1_ended", b0.ended, 1);
    chk("t1_pass", b0.pass, 1);
    chk("t1_fail", b0.fail, 0);
    b0.end_cond = 0;
    tick();
    chk("t1_ended2_lo", b0.ended2, 0);
    chk("t1_pass_lo", b0.pass, 0);
    b0.end_cond = 1;
    tick();
    chk("t1_ended2", b0.ended2, 1);
    chk("t1_pass2", b0.pass, 1);
    chk("t1_icount", b0.instr_count, 1);
    b0.end_cond = 0;

    // ---- END_MIN=2 / END_MAX=4: timeout ----
    b1.issue = 1; b1.ila_valid = 1; b1.ila_decode = 1;
    b1.map_ok = '1; b1.map_ok[3] = 0;
    tick();
    b1.issue = 0;
    tick();
    chk("t3_cnt1", b1.cycle_cnt, 1);
    b1.end_cond = 1;
    tick();
    chk("t3_early_end_ignored", b1.ended, 0);
    b1.end_cond = 0;
    tick(); tick();
    chk("t3_cnt4", b1.cycle_cnt, 4);
    chk("t3_no_to_yet", b1.timeout, 0);
    tick();
    chk("t3_timeout", b1.timeout, 1);
    chk("t3_fail", b1.fail, 1);
    chk("t3_pass_lo", b1.pass, 0);
    chk("t3_cnt5", b1.cycle_cnt, 5);
    chk("t3_ended", b1.ended, 1);
    chk("t3_idx", b1.fail_map_idx, 0);
    chk("t3_fcycle", b1.fail_cycle, 4);

    // ---- REPEAT=1: three windows, second fails on lane 17 ----
    b2.ila_valid = 1; b2.ila_decode = 1; b2.issue = 1;
    tick();
    chk("t4_w1_start", b2.start, 1);
    b2.issue = 0;
    tick();
    b2.end_cond = 1;
    tick();
    chk("t4_w1_pass", b2.pass, 1);
    tick();
    chk("t4_w1_icount", b2.instr_count, 1);
    chk("t4_w1_started_clr", b2.started, 0);
    chk("t4_w1_cnt_clr", b2.cycle_cnt, 0);
    b2.end_cond = 0; b2.issue = 1;
    tick();
    b2.issue = 0;
    tick();
    b2.end_cond = 1; b2.map_ok[17] = 0;
    tick();
    chk("t4_w2_fail", b2.fail, 1);
    chk("t4_w2_idx", b2.fail_map_idx, 17);
    chk("t4_w2_fcycle", b2.fail_cycle, 1);
    b2.map_ok = '1;
    tick();
    chk("t4_w2_pass2", b2.pass, 1);
    chk("t4_w2_icount", b2.instr_count, 2);
    b2.end_cond = 0; b2.issue = 1;
    tick();
    b2.issue = 0;
    tick();
    b2.issue = 1; b2.end_cond = 1;
    tick();
    chk("t4_w3_pass", b2.pass, 1);
    b2.issue = 0;
    tick();
    chk("t4_w3_icount", b2.instr_count, 3);
    chk("t4_w3_idx_kept", b2.fail_map_idx, 17);
    chk("t4_w3_sticky", b2.fail_sticky, 1);
    b2.end_cond = 0;
    tick();
    chk("t4_issue_dropped", b2.start, 0);
    chk("t4_idle_started", b2.started, 0);

    // ---- defaults: mismatch on lanes 4 and 9, then masked ----
    rst = 1;
    tick();
    rst = 0;
    b0.issue = 1; b0.map_ok = '1; b0.map_en = '1; b0.end_cond = 0;
    tick();
    b0.issue = 0;
    tick();
    b0.end_cond = 1; b0.map_ok[4] = 0; b0.map_ok[9] = 0;
    tick();
    chk("t2_fail", b0.fail, 1);
    chk("t2_pass_lo", b0.pass, 0);
    chk("t2_idx", b0.fail_map_idx, 4);
    chk("t2_fcycle", b0.fail_cycle, 1);
    chk("t2_sticky", b0.fail_sticky, 1);
    b0.map_en[4] = 0; b0.map_en[9] = 0;
    tick();
    chk("t2_masked_pass", b0.pass, 1);
    chk("t2_masked_fail_lo", b0.fail, 0);
    chk("t2_idx_kept", b0.fail_map_idx, 4);
    b0.end_cond = 0; b0.map_ok = '1; b0.map_en = '1;

    // ---- reset mid-RUN (END window 2..4) then a clean window ----
    rst = 1;
    tick();
    rst = 0;
    b1.issue = 1; b1.map_ok = '1; b1.end_cond = 0;
    tick();
    b1.issue = 0;
    tick(); tick();
    chk("t5_cnt2", b1.cycle_cnt, 2);
    rst = 1; b1.end_cond = 1;
    tick();
    chk("t5_started_clr", b1.started, 0);
    chk("t5_cnt_clr", b1.cycle_cnt, 0);
    chk("t5_pass_lo", b1.pass, 0);
    chk("t5_fail_lo", b1.fail, 0);
    chk("t5_ended_clr", b1.ended, 0);
    rst = 0; b1.end_cond = 0;
    tick();
    chk("t5_pass_lo2", b1.pass, 0);
    chk("t5_fail_lo2", b1.fail, 0);
    b1.issue = 1;
    tick();
    b1.issue = 0;
    tick(); tick();
    b1.end_cond = 1;
    tick();
    chk("t5_pass", b1.pass, 1);
    chk("t5_cnt3", b1.cycle_cnt, 3);
    tick();
    chk("t5_ended2", b1.ended2, 1);
    chk("t5_icount", b1.instr_count, 1);
    b1.end_cond = 0;

    // ---- defaults: saturate cycle_cnt, then hold in DONE ----
    rst = 1;
    tick();
    rst = 0;
    b0.issue = 1;
    tick();
    b0.issue = 0;
    tick();
    b0.end_cond = 1;
    tick();
    b0.end_cond = 0;
    for (int i = 0; i < 6; i++) tick();
    chk("t6_cnt_sat", b0.cycle_cnt, 6);
    b0.end_cond = 1;
    tick();
    chk("t6_ended2", b0.ended2, 1);
    b0.end_cond = 0; b0.issue = 1;
    for (int i = 0; i < 20; i++) tick();
    chk("t6_done_cnt", b0.cycle_cnt, 6);
    chk("t6_done_start", b0.start, 0);
    chk("t6_done_icount", b0.instr_count, 1);
    chk("t6_done_started", b0.started, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
